// File: rtl/cpu31_pkg.sv
// Shared CPU constants: ALU function codes, MIPS opcode/funct values, issue payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu31_pkg;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_ADDU = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_SUBU = 6'd3,
    ALU_AND  = 6'd4,
    ALU_OR   = 6'd5,
    ALU_XOR  = 6'd6,
    ALU_NOR  = 6'd7,
    ALU_SLT  = 6'd8,
    ALU_SLTU = 6'd9,
    ALU_SLL  = 6'd10,
    ALU_SRL  = 6'd11,
    ALU_SRA  = 6'd12,
    ALU_SLLV = 6'd13,
    ALU_SRLV = 6'd14,
    ALU_SRAV = 6'd15,
    ALU_LUI  = 6'd16
  } alu_func_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct field (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Decoded ALU payload held by the issue register
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  func;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// MIPS instruction to ALU operand/function decode; unknown encodings become a harmless ADDU 0,0.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module alu_decode
  import cpu31_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_func,
  output logic        illegal
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm;
  alu_func_e   func_d;
  logic [31:0] a_d;
  logic [31:0] b_d;
  logic        bad;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // Select function and operands; I-type defaults to rs / sign-extended imm
  always_comb begin
    func_d = ALU_ADDU;
    a_d    = rs_val;
    b_d    = sext16(imm);
    bad    = 1'b0;
    case (op)
      OP_RTYPE: begin
        b_d = rt_val;
        case (funct)
          FN_ADD:  func_d = ALU_ADD;
          FN_ADDU: func_d = ALU_ADDU;
          FN_SUB:  func_d = ALU_SUB;
          FN_SUBU: func_d = ALU_SUBU;
          FN_AND:  func_d = ALU_AND;
          FN_OR:   func_d = ALU_OR;
          FN_XOR:  func_d = ALU_XOR;
          FN_NOR:  func_d = ALU_NOR;
          FN_SLT:  func_d = ALU_SLT;
          FN_SLTU: func_d = ALU_SLTU;
          FN_SLL:  begin func_d = ALU_SLL; a_d = {27'b0, instr[10:6]}; end
          FN_SRL:  begin func_d = ALU_SRL; a_d = {27'b0, instr[10:6]}; end
          FN_SRA:  begin func_d = ALU_SRA; a_d = {27'b0, instr[10:6]}; end
          FN_SLLV: func_d = ALU_SLLV;
          FN_SRLV: func_d = ALU_SRLV;
          FN_SRAV: func_d = ALU_SRAV;
          default: bad = 1'b1;
        endcase
      end
      OP_ADDI:                  func_d = ALU_ADD;
      OP_ADDIU, OP_LW, OP_SW:   func_d = ALU_ADDU;
      OP_SLTI:                  func_d = ALU_SLT;
      OP_SLTIU:                 func_d = ALU_SLTU;
      OP_BEQ, OP_BNE:           func_d = ALU_SUBU;
      OP_ANDI: begin func_d = ALU_AND; b_d = zext16(imm); end
      OP_ORI:  begin func_d = ALU_OR;  b_d = zext16(imm); end
      OP_XORI: begin func_d = ALU_XOR; b_d = zext16(imm); end
      OP_LUI:  begin func_d = ALU_LUI; b_d = zext16(imm); end
      default: bad = 1'b1;
    endcase
  end

  assign alu_a    = bad ? 32'h0 : a_d;
  assign alu_b    = bad ? 32'h0 : b_d;
  assign alu_func = bad ? ALU_ADDU : func_d;
  assign illegal  = bad;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an offered instruction and holds it in a one-entry skid-free register.
// Latency: one cycle from accepted offer to out_valid.
// Backpressure: in_ready = !out_valid | out_ready, so a full register stalls upstream until drained.
module alu_issue_stage
  import cpu31_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_func,
  output logic        illegal,
  output logic [31:0] issue_cnt
);

  issue_t      dec;
  issue_t      held_q;
  logic        vld_q;
  logic [31:0] cnt_q;
  logic        accept;

  alu_decode u_decode (
    .instr    (instr),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_a    (dec.a),
    .alu_b    (dec.b),
    .alu_func (dec.func),
    .illegal  (dec.illegal)
  );

  assign in_ready = !vld_q || out_ready;
  // flush drops the current offer, so it never counts as a transfer in
  assign accept   = in_valid && in_ready && !flush;

  // Entry valid flag: flush kills, accept loads, drain clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  // Payload only changes on accept, so it stays stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
    end else if (accept) begin
      held_q <= dec;
    end
  end

  // Accepted-instruction counter, wraps naturally, ignores flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'h0;
    end else if (accept) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign out_valid = vld_q;
  assign alu_a     = held_q.a;
  assign alu_b     = held_q.b;
  assign alu_func  = held_q.func;
  assign illegal   = held_q.illegal;
  assign issue_cnt = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid  in  1  instruction offered; in_ready  out  1  stage can accept.
REQ-003 SHALL have ports: instr  in  32  MIPS instruction word; rs_val  in  32  rs register value; rt_val  in  32  rt register value.
REQ-004 SHALL have ports: flush  in  1  synchronous kill of held entry and of the current offer.
REQ-005 SHALL have ports: out_valid  out  1  entry valid; out_ready  in  1  downstream ALU/EX accepts.
REQ-006 SHALL have ports: alu_a  out  32  ALU operand a; alu_b  out  32  ALU operand b; alu_func  out  6  ALU operation code.
REQ-007 SHALL have ports: illegal  out  1  held instruction undecodable; issue_cnt  out  32  accepted-instruction count.

Function
REQ-010 alu_func codes SHALL be ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, NOR 7, SLT 8, SLTU 9, SLL 10, SRL 11, SRA 12, SLLV 13, SRLV 14, SRAV 15, LUI 16.
REQ-011 op=0 SHALL decode by funct: 20h ADD, 21h ADDU, 22h SUB, 23h SUBU, 24h AND, 25h OR, 26h XOR, 27h NOR, 2Ah SLT, 2Bh SLTU, 00h SLL, 02h SRL, 03h SRA, 04h SLLV, 06h SRLV, 07h SRAV.
REQ-012 I-type SHALL decode: addi ADD, addiu ADDU, slti SLT, sltiu SLTU, andi AND, ori OR, xori XOR, lui LUI, lw/sw ADDU, beq/bne SUBU.
REQ-013 R-type operands SHALL be a=rs_val, b=rt_val, except SLL/SRL/SRA where a={27'b0,instr[10:6]}.
REQ-014 I-type b SHALL be imm16 zero-extended for andi/ori/xori/lui, sign-extended otherwise; a=rs_val.
REQ-015 Any other op/funct SHALL issue alu_func=ADDU, alu_a=alu_b=0, illegal=1; never blocks the pipe.
REQ-016 in_ready SHALL equal !out_valid | out_ready (combinational, no bubble on continuous streaming).
REQ-017 Transfer in SHALL occur when in_valid & in_ready & !flush; decoded fields registered same edge; out_valid=1 next cycle.
REQ-018 Transfer out SHALL occur when out_valid & out_ready; without a simultaneous transfer in, out_valid clears.
REQ-019 While out_valid & !out_ready, alu_a/alu_b/alu_func/illegal SHALL hold stable.
REQ-020 flush SHALL clear out_valid next edge and win over a simultaneous in_valid (offer dropped, not counted).
REQ-021 issue_cnt SHALL increment by 1 per transfer in, wrap 32'hFFFFFFFF -> 0, unaffected by flush.
REQ-022 Latency SHALL be exactly one cycle from accepted input to out_valid.

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, alu_a=0, alu_b=0, alu_func=0, illegal=0, issue_cnt=0, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard the held entry; first accept permitted on the first rising edge after rst_n deasserts.

Structure
REQ-040 ALU function codes (REQ-010), opcode and funct constants SHALL live in shared package cpu31_pkg, also used by the ALU.
REQ-041 Decode SHALL be a combinational sub-module alu_decode (instr, rs_val, rt_val -> alu_a, alu_b, alu_func, illegal); the handshake register and counter stay in alu_issue_stage.

Verification
REQ-050 add $1,$2,$3 (rs=5, rt=7), out_ready=1 -> next cycle out_valid=1, alu_func=0, a=5, b=7, issue_cnt=1.
REQ-051 andi imm=16'h8001 -> b=32'h00008001; addi imm=16'h8001 -> b=32'hFFFF8001; sll shamt=4 rt=3 -> a=4, b=3, func=10.
REQ-052 out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> one transfer out, next instruction accepted same edge.
REQ-053 flush and in_valid same cycle while holding an entry -> out_valid=0 next cycle, issue_cnt unchanged.
REQ-054 instr op=6'h3F -> illegal=1, func=1, a=b=0; issue_cnt preloaded 32'hFFFFFFFF then one accept -> 0.
REQ-055 rst_n pulsed low between clock edges while out_valid=1 -> out_valid and all outputs 0 before the next edge.
